// File: rtl/mac_accumulator_4bit.sv
// Sums COUNT unsigned 8-bit products into one saturating ACC_W-bit result with a sticky overflow flag.
// Latency: the result is registered and visible the cycle after the COUNT-th accepted product.
// Backpressure: in_ready drops while a result is pending; products are stalled until out_ready takes it.
module mac_accumulator_4bit #(
    parameter int COUNT = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [7:0]       COUNT_L = 8'(COUNT);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   add_full;
    logic             add_carry;
    logic [ACC_W-1:0] nxt_acc;
    logic             nxt_ovf;
    logic [7:0]       nxt_cnt;
    logic             last;

    // Handshake and next-value datapath; the first product of a batch loads rather than adds
    always_comb begin
        in_ready  = (state != DONE);
        accept    = in_valid && in_ready;
        prod_ext  = {{(ACC_W - 7){1'b0}}, product};
        add_full  = {1'b0, acc} + prod_ext;
        add_carry = add_full[ACC_W];
        nxt_acc   = add_carry ? ACC_MAX : add_full[ACC_W-1:0];
        nxt_ovf   = ovf | add_carry;
        nxt_cnt   = count + 8'd1;
        if (state == IDLE) begin
            nxt_acc = prod_ext[ACC_W-1:0];
            nxt_ovf = 1'b0;
            nxt_cnt = 8'd1;
        end
        last = (nxt_cnt == COUNT_L);
    end

    // Batch FSM: accumulate, present the result, wait for the sink, then restart
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= 8'd0;
            sum       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            // abort: any in-flight product and any pending result are discarded
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= 8'd0;
            sum       <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= nxt_acc;
                        ovf   <= nxt_ovf;
                        count <= nxt_cnt;
                        if (last) begin
                            state     <= DONE;
                            sum       <= nxt_acc;
                            out_ovf   <= nxt_ovf;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        count     <= 8'd0;
                        out_ovf   <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// Bench for mac_accumulator_4bit: two instances (COUNT=6/ACC_W=16 and COUNT=8/ACC_W=10) share stimulus.
// Both are compared every cycle against a batch-sum model; directed tables and sequences cover corners.
// Inputs change on the falling edge, outputs are sampled on the falling edge after each rising edge.
module tb_mac_accumulator_4bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, in_valid, out_ready;
    logic [7:0] product;

    logic        ir6, ov6, ovf6;
    logic [15:0] sum6;
    logic [7:0]  cnt6;
    logic        ir8, ov8, ovf8;
    logic [9:0]  sum8;
    logic [7:0]  cnt8;

    mac_accumulator_4bit #(.COUNT(6), .ACC_W(16)) dut6 (
        .clk(clk), .rst(rst), .clear(clear), .product(product), .in_valid(in_valid),
        .in_ready(ir6), .sum(sum6), .out_ovf(ovf6), .out_valid(ov6),
        .out_ready(out_ready), .count(cnt6)
    );

    mac_accumulator_4bit #(.COUNT(8), .ACC_W(10)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .product(product), .in_valid(in_valid),
        .in_ready(ir8), .sum(sum8), .out_ovf(ovf8), .out_valid(ov8),
        .out_ready(out_ready), .count(cnt8)
    );

    // Reference: a batch is just a running count and an exact integer total;
    // the delivered result is min(total, 2^ACC_W-1) and overflow is total > max.
    typedef struct {
        int     n;
        longint total;
        bit     done;
        longint sum;
        bit     ovf;
    } mdl_t;

    mdl_t m6, m8;
    int   total_checks = 0;
    int   passed = 0;

    function automatic mdl_t step(input mdl_t m, input int cnt, input int accw);
        longint mx;
        mx = (longint'(1) << accw) - 1;
        if (rst) begin
            m = '{default: 0};
        end else if (clear) begin
            m.n = 0; m.total = 0; m.done = 0; m.ovf = 0; m.sum = 0;
        end else if (m.done) begin
            if (out_ready) begin
                m.done = 0; m.n = 0; m.total = 0;
            end
        end else if (in_valid) begin
            m.total += longint'(product);
            m.n++;
            if (m.n == cnt) begin
                m.done = 1;
                m.ovf  = (m.total > mx);
                m.sum  = (m.total > mx) ? mx : m.total;
            end
        end
        return m;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total_checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_model();
        chk("m6.out_valid", longint'(ov6), longint'(m6.done));
        chk("m6.count",     longint'(cnt6), longint'(m6.n));
        chk("m6.in_ready",  longint'(ir6), longint'(!m6.done));
        if (m6.done) begin
            chk("m6.sum", longint'(sum6), m6.sum);
            chk("m6.ovf", longint'(ovf6), longint'(m6.ovf));
        end
        chk("m8.out_valid", longint'(ov8), longint'(m8.done));
        chk("m8.count",     longint'(cnt8), longint'(m8.n));
        chk("m8.in_ready",  longint'(ir8), longint'(!m8.done));
        if (m8.done) begin
            chk("m8.sum", longint'(sum8), m8.sum);
            chk("m8.ovf", longint'(ovf8), longint'(m8.ovf));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m6 = step(m6, 6, 16);
        m8 = step(m8, 8, 10);
        @(negedge clk);
        chk_model();
    endtask

    task automatic drv(input logic r, input logic c, input logic v, input logic [7:0] p, input logic o);
        rst = r; clear = c; in_valid = v; product = p; out_ready = o;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] p;
        logic       ordy;
        logic       ev;
        int         esum;
        int         ecnt;
        logic       eir;
        logic       eovf;
    } vec_t;

    initial begin
        vec_t       tbl [7];
        logic [7:0] stream [6];

        tbl[0] = '{1'b1, 8'd144, 1'b1, 1'b0,   0, 1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'd16,  1'b1, 1'b0,   0, 2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'd36,  1'b1, 1'b0,   0, 3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'd3,   1'b1, 1'b0,   0, 4, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'd90,  1'b1, 1'b0,   0, 5, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'd6,   1'b1, 1'b1, 295, 6, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'd0,   1'b1, 1'b0,   0, 0, 1'b1, 1'b0};
        stream = '{8'd144, 8'd16, 8'd36, 8'd3, 8'd90, 8'd6};

        m6 = '{default: 0};
        m8 = '{default: 0};
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

        // reset, then idle cycles
        tick();
        chk("reset.sum6", longint'(sum6), 0);
        chk("reset.sum8", longint'(sum8), 0);
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
            tick();
            chk("idle.sum6", longint'(sum6), 0);
            chk("idle.in_ready6", longint'(ir6), 1);
        end

        // back-to-back batch with sink always ready (table)
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drv(1'b0, 1'b0, tbl[i].v, tbl[i].p, tbl[i].ordy);
            tick();
            chk("tbl.out_valid", longint'(ov6), longint'(tbl[i].ev));
            chk("tbl.count",     longint'(cnt6), longint'(tbl[i].ecnt));
            chk("tbl.in_ready",  longint'(ir6), longint'(tbl[i].eir));
            if (tbl[i].ev) begin
                chk("tbl.sum", longint'(sum6), longint'(tbl[i].esum));
                chk("tbl.ovf", longint'(ovf6), longint'(tbl[i].eovf));
            end
        end

        // gapped input, then back-pressure with a product waiting upstream
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, 1'b1, stream[i], 1'b0);
            tick();
            if (i < 5) begin
                drv(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
                tick();
                tick();
            end
        end
        chk("bp.out_valid", longint'(ov6), 1);
        chk("bp.sum", longint'(sum6), 295);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b0, 1'b1, 8'd77, 1'b0);
            tick();
            chk("bp.hold_sum", longint'(sum6), 295);
            chk("bp.in_ready", longint'(ir6), 0);
            chk("bp.count", longint'(cnt6), 6);
        end
        drv(1'b0, 1'b0, 1'b1, 8'd77, 1'b1);
        tick();
        chk("bp.handoff_valid", longint'(ov6), 0);
        chk("bp.handoff_count", longint'(cnt6), 0);
        chk("bp.handoff_ready", longint'(ir6), 1);
        drv(1'b0, 1'b0, 1'b1, 8'd77, 1'b0);
        tick();
        chk("bp.next_first", longint'(cnt6), 1);

        // saturation on the 10-bit instance, then a clean batch
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b0, 1'b1, 8'd225, 1'b0);
            tick();
        end
        chk("sat.out_valid", longint'(ov8), 1);
        chk("sat.sum", longint'(sum8), 1023);
        chk("sat.ovf", longint'(ovf8), 1);
        drv(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
            tick();
        end
        chk("sat.next_sum", longint'(sum8), 8);
        chk("sat.next_ovf", longint'(ovf8), 0);

        // clear mid-batch leaves no residue
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 1'b1, stream[i], 1'b0);
            tick();
        end
        chk("clr.count_before", longint'(cnt6), 3);
        drv(1'b0, 1'b1, 1'b1, 8'd200, 1'b0);
        tick();
        chk("clr.count", longint'(cnt6), 0);
        chk("clr.in_ready", longint'(ir6), 1);
        for (int k = 1; k <= 6; k++) begin
            drv(1'b0, 1'b0, 1'b1, 8'(k), 1'b0);
            tick();
        end
        chk("clr.out_valid", longint'(ov6), 1);
        chk("clr.sum", longint'(sum6), 21);
        chk("clr.ovf", longint'(ovf6), 0);

        // reset while a result is pending, and reset together with in_valid
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, 1'b1, 8'd10, 1'b0);
            tick();
        end
        chk("rst.pending", longint'(ov6), 1);
        chk("rst.pending_sum", longint'(sum6), 60);
        drv(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        chk("rst.out_valid", longint'(ov6), 0);
        chk("rst.sum", longint'(sum6), 0);
        chk("rst.count", longint'(cnt6), 0);
        chk("rst.in_ready", longint'(ir6), 1);
        drv(1'b1, 1'b0, 1'b1, 8'd50, 1'b0);
        tick();
        chk("rst.no_accept", longint'(cnt6), 0);
        drv(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        tick();
        chk("rst.after", longint'(cnt6), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 199) == 0,
                $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7,
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 40)),
                1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
